// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADD_REG    = 5;
    localparam int DEF_REG_DEPTH  = 32;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: range check, zero-register force and
// write-to-read forwarding in front of the stored word.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADD_REG    = DEF_ADD_REG,
    parameter int REG_DEPTH  = DEF_REG_DEPTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                                  run_i,
    input  logic [ADD_REG-1:0]                    rs_i,
    input  logic [REG_DEPTH-1:0][DATA_WIDTH-1:0]  mem_i,
    input  logic                                  we0_i,
    input  logic [ADD_REG-1:0]                    rd0_i,
    input  logic [DATA_WIDTH-1:0]                 wd0_i,
    input  logic                                  we1_i,
    input  logic [ADD_REG-1:0]                    rd1_i,
    input  logic [DATA_WIDTH-1:0]                 wd1_i,
    output logic [DATA_WIDTH-1:0]                 rdata_o
);

    localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    logic in_range, is_zero, hit0, hit1;

    assign in_range = ({1'b0, rs_i} < (ADD_REG + 1)'(REG_DEPTH));
    assign is_zero  = (ZERO_REG != 0) && (rs_i == '0);
    assign hit1     = (BYPASS != 0) && we1_i && (rd1_i == rs_i);
    assign hit0     = (BYPASS != 0) && we0_i && (rd0_i == rs_i);

    // Port 1 wins the forward, matching its priority on the write side.
    always_comb begin
        rdata_o = '0;
        if (run_i && in_range && !is_zero) begin
            if (hit1)
                rdata_o = wd1_i;
            else if (hit0)
                rdata_o = wd0_i;
            else
                rdata_o = mem_i[IDX_W'(rs_i)];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD read ports,
// and a one-register-per-cycle clear sweep gating the ready flag.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADD_REG    = DEF_ADD_REG,
    parameter int REG_DEPTH  = DEF_REG_DEPTH,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         we0,
    input  logic [ADD_REG-1:0]           rd0,
    input  logic [DATA_WIDTH-1:0]        wd0,
    input  logic                         we1,
    input  logic [ADD_REG-1:0]           rd1,
    input  logic [DATA_WIDTH-1:0]        wd1,
    input  logic [NUM_RD*ADD_REG-1:0]    rs,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic                         ready
);

    localparam int CNT_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REG_DEPTH - 1);

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                ready_q, ready_d;
    logic [REG_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

    logic sweep_we, wr_en, wr0_ok, wr1_ok;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        sweep_we = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clear) begin
                    cnt_d = '0;
                end else begin
                    sweep_we = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end else begin
                    wr_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign wr0_ok = wr_en && we0 && ({1'b0, rd0} < (ADD_REG + 1)'(REG_DEPTH))
                    && !((ZERO_REG != 0) && (rd0 == '0));
    assign wr1_ok = wr_en && we1 && ({1'b0, rd1} < (ADD_REG + 1)'(REG_DEPTH))
                    && !((ZERO_REG != 0) && (rd1 == '0));

    // Storage is never reset; the sweep is what brings it to zero.
    // Port 1 is assigned last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (sweep_we) begin
                mem_q[cnt_q] <= '0;
            end else begin
                if (wr0_ok) mem_q[CNT_W'(rd0)] <= wd0;
                if (wr1_ok) mem_q[CNT_W'(rd1)] <= wd1;
            end
        end
    end

    assign ready = ready_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADD_REG    (ADD_REG),
            .REG_DEPTH  (REG_DEPTH),
            .ZERO_REG   (ZERO_REG),
            .BYPASS     (BYPASS)
        ) u_rd_port (
            .run_i   (state_q == ST_RUN),
            .rs_i    (rs[g*ADD_REG +: ADD_REG]),
            .mem_i   (mem_q),
            .we0_i   (we0),
            .rd0_i   (rd0),
            .wd0_i   (wd0),
            .we1_i   (we1),
            .rd1_i   (rd1),
            .wd1_i   (wd1),
            .rdata_o (rdata[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three configurations driven in lockstep and
// checked every cycle against a behavioural register-file model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset, clear, we0, we1;
    logic [4:0]  rd0, rd1;
    logic [31:0] wd0, wd1;
    logic [9:0]  rs;
    logic [63:0] rdata_a, rdata_b, rdata_s;
    logic        ready_a, ready_b, ready_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // a: defaults with bypass, b: no bypass, s: 20 registers (addresses 20..31 out of range)
    regfile_mp #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .we0(we0), .rd0(rd0), .wd0(wd0),
        .we1(we1), .rd1(rd1), .wd1(wd1), .rs(rs), .rdata(rdata_a), .ready(ready_a));
    regfile_mp #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .we0(we0), .rd0(rd0), .wd0(wd0),
        .we1(we1), .rd1(rd1), .wd1(wd1), .rs(rs), .rdata(rdata_b), .ready(ready_b));
    regfile_mp #(.REG_DEPTH(20), .BYPASS(1)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .we0(we0), .rd0(rd0), .wd0(wd0),
        .we1(we1), .rd1(rd1), .wd1(wd1), .rs(rs), .rdata(rdata_s), .ready(ready_s));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int          depth [3] = '{32, 32, 20};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
    bit          m_valid = 1'b0;
    bit          m_ready [3];
    int          m_swept [3];
    logic [31:0] m_mem   [3][32];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_ready[k] = 1'b0;
                m_swept[k] = 0;
            end else if (!m_ready[k]) begin
                if (clear) m_swept[k] = 0;
                else begin
                    m_mem[k][m_swept[k]] = 32'h0;
                    m_swept[k]++;
                    if (m_swept[k] == depth[k]) m_ready[k] = 1'b1;
                end
            end else if (clear) begin
                m_ready[k] = 1'b0;
                m_swept[k] = 0;
            end else begin
                if (we0 && int'(rd0) < depth[k] && rd0 != 0) m_mem[k][rd0] = wd0;
                if (we1 && int'(rd1) < depth[k] && rd1 != 0) m_mem[k][rd1] = wd1;
            end
        end
        if (!reset) m_valid = 1'b1;
    end

    function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
        if (!m_ready[k] || int'(a) >= depth[k] || a == 0) return 32'h0;
        if (byp[k] && we1 && rd1 == a) return wd1;
        if (byp[k] && we0 && rd0 == a) return wd0;
        return m_mem[k][a];
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready_a", {31'h0, ready_a}, {31'h0, m_ready[0]});
            chk("ready_b", {31'h0, ready_b}, {31'h0, m_ready[1]});
            chk("ready_s", {31'h0, ready_s}, {31'h0, m_ready[2]});
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rd_a[%0d]@%0d", p, rs[p*5 +: 5]), rdata_a[p*32 +: 32], exp_rd(0, rs[p*5 +: 5]));
                chk($sformatf("rd_b[%0d]@%0d", p, rs[p*5 +: 5]), rdata_b[p*32 +: 32], exp_rd(1, rs[p*5 +: 5]));
                chk($sformatf("rd_s[%0d]@%0d", p, rs[p*5 +: 5]), rdata_s[p*32 +: 32], exp_rd(2, rs[p*5 +: 5]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_wait(input string nm);
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e == 19) chk({nm, "_s_lo"}, {31'h0, ready_s}, 32'h0);
            if (e == 20) chk({nm, "_s_hi"}, {31'h0, ready_s}, 32'h1);
            if (e == 31) chk({nm, "_a_lo"}, {31'h0, ready_a}, 32'h0);
            if (e == 32) chk({nm, "_a_hi"}, {31'h0, ready_a}, 32'h1);
        end
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; we0 = 1'b0; we1 = 1'b0;
        rd0 = '0; rd1 = '0; wd0 = '0; wd1 = '0; rs = '0;
        repeat (3) tick();
        chk("reset_ready", {31'h0, ready_a}, 32'h0);
        chk("reset_rdata", rdata_a[31:0], 32'h0);
        reset = 1'b1;
        sweep_wait("sweep1");

        for (int r = 0; r < 32; r += 2) begin
            rs = {5'(r + 1), 5'(r)};
            tick();
        end

        // same-cycle forward on a, stored value next cycle on both
        we0 = 1'b1; rd0 = 5'd5; wd0 = 32'hDEADBEEF; rs = {5'd5, 5'd5};
        #1 chk("byp_a", rdata_a[31:0], 32'hDEADBEEF);
        chk("nobyp_b", rdata_b[31:0], 32'h0);
        tick(); we0 = 1'b0;
        #1 chk("basic_p0", rdata_a[31:0], 32'hDEADBEEF);
        chk("basic_p1", rdata_a[63:32], 32'hDEADBEEF);

        we0 = 1'b1; rd0 = 5'd7; wd0 = 32'h33;
        tick();
        we1 = 1'b1; rd1 = 5'd7; wd0 = 32'h11; wd1 = 32'h22; rs = {5'd7, 5'd7};
        #1 chk("coll_byp_a", rdata_a[31:0], 32'h22);
        chk("coll_old_b", rdata_b[31:0], 32'h33);
        tick(); we0 = 1'b0; we1 = 1'b0;
        #1 chk("coll_a", rdata_a[31:0], 32'h22);
        chk("coll_b", rdata_b[31:0], 32'h22);

        we1 = 1'b1; rd1 = 5'd0; wd1 = 32'hFFFF; rs = {5'd0, 5'd0};
        #1 chk("zero_same", rdata_a[31:0], 32'h0);
        tick(); we1 = 1'b0;
        #1 chk("zero_next", rdata_a[63:32], 32'h0);

        we0 = 1'b1; rd0 = 5'd25; wd0 = 32'h55;
        we1 = 1'b1; rd1 = 5'd10; wd1 = 32'h77; rs = {5'd10, 5'd25};
        #1 chk("oor_s_byp", rdata_s[31:0], 32'h0);
        chk("inr_s_byp", rdata_s[63:32], 32'h77);
        tick(); we0 = 1'b0; we1 = 1'b0;
        #1 chk("oor_s", rdata_s[31:0], 32'h0);
        chk("inr_s", rdata_s[63:32], 32'h77);
        chk("r25_a", rdata_a[31:0], 32'h55);

        // clear in RUN drops the write issued with it
        we0 = 1'b1; rd0 = 5'd3; wd0 = 32'hA5;
        tick();
        rd0 = 5'd4; wd0 = 32'h5A; clear = 1'b1;
        tick();
        clear = 1'b0; we0 = 1'b0;
        we1 = 1'b1; rd1 = 5'd9; wd1 = 32'h99; rs = {5'd9, 5'd9};
        sweep_wait("sweep2");
        we1 = 1'b0; rs = {5'd4, 5'd3};
        #1 chk("clr_r3", rdata_a[31:0], 32'h0);
        chk("clr_r4", rdata_a[63:32], 32'h0);
        tick();
        rs = {5'd9, 5'd9};
        tick();

        // reset mid-sweep restarts from register 0
        we0 = 1'b1; rd0 = 5'd12; wd0 = 32'hBAD;
        tick();
        we0 = 1'b0; rs = {5'd12, 5'd12};
        #1 chk("pre_r12", rdata_a[31:0], 32'hBAD);
        clear = 1'b1;
        tick();
        clear = 1'b0; we0 = 1'b1; wd0 = 32'h123;
        repeat (10) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        sweep_wait("sweep3");
        we0 = 1'b0;
        #1 chk("post_r12", rdata_a[31:0], 32'h0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the single-write/dual-read CPU register file of the single-cycle RISC-V core. It adds:

- a configurable number of combinational read ports;
- two write ports with defined priority;
- optional write-to-read bypass and a hardwired zero register;
- a sequential clear sweep that replaces the old all-at-once reset loop, with a `ready` flag.

It sits between decode (register addresses) and writeback (write data) in the datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADD_REG, 5, register address width
- REG_DEPTH, 32, number of registers; must satisfy REG_DEPTH ≤ 2^ADD_REG
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- clear  in  1  synchronous soft-clear request; restarts the clear sweep
- we0  in  1  write enable, port 0
- rd0  in  ADD_REG  write address, port 0
- wd0  in  DATA_WIDTH  write data, port 0
- we1  in  1  write enable, port 1; has priority over port 0
- rd1  in  ADD_REG  write address, port 1
- wd1  in  DATA_WIDTH  write data, port 1
- rs  in  NUM_RD*ADD_REG  packed read addresses; port i uses bits [i*ADD_REG +: ADD_REG]
- rdata  out  NUM_RD*DATA_WIDTH  packed read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- ready  out  1  1 = file is cleared and in normal operation

## Operation
State machine, two states: ST_CLEAR and ST_RUN.

- **reset == 0 at an edge:** state ← ST_CLEAR, sweep counter cnt ← 0, ready ← 0. Registers are not touched during reset. Holding reset low keeps the block in ST_CLEAR with cnt = 0.
- **ST_CLEAR (reset == 1):**
  - Each edge: reg[cnt] ← 0, cnt ← cnt + 1.
  - On the edge where cnt == REG_DEPTH−1: write the last register, go to ST_RUN, ready ← 1.
  - we0/we1 are ignored.
  - All rdata ports read 0.
  - clear == 1 in this state restarts the sweep: cnt ← 0, and no register is written on that edge.
- **ST_RUN:**
  - clear == 1 at an edge: go to ST_CLEAR, cnt ← 0, ready ← 0. Any write on that same edge is dropped.
  - Otherwise, writes proceed:
    - we0 && rd0 in range → reg[rd0] ← wd0.
    - we1 && rd1 in range → reg[rd1] ← wd1.
    - rd0 == rd1 with both enabled → wd1 wins.
  - Addresses ≥ REG_DEPTH: writes are dropped, and reads at those addresses return 0.
- **ZERO_REG = 1:**
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 regardless of bypass.
  - The sweep still writes reg[0].
- **Reads (ST_RUN):**
  - rdata[i] = reg[rs[i]], combinational.
  - With BYPASS = 1, a matching enabled write in the same cycle is forwarded instead:
    - we1 && rd1 == rs[i] → wd1;
    - else we0 && rd0 == rs[i] → wd0;
    - else the stored value.
  - Bypass is not applied for address 0 when ZERO_REG = 1, nor for out-of-range addresses.
- **BYPASS = 0:** reads return the pre-edge stored value (the new value is visible in the next cycle).

## Timing
- Read latency: 0 cycles (combinational from rs, state and write ports).
- Write latency: 1 edge.
- Reset values: ready = 0; rdata = 0 on all ports (forced by ST_CLEAR).
- Clear duration: ready rises after exactly REG_DEPTH edges with reset == 1 and clear == 0, counted from the first such edge after reset or clear.
- Reset has priority over clear; clear has priority over writes.
- Reset or clear mid-sweep restarts the sweep from register 0.
- cnt width is clog2(REG_DEPTH) bits, so it does not wrap during a sweep.

## Structure
- Shared package regfile_pkg:
  - state enum {ST_CLEAR, ST_RUN};
  - localparam defaults for DATA_WIDTH, ADD_REG and REG_DEPTH, matching the core's 32/5/32.
- Sub-module regfile_rd_port, instantiated NUM_RD times via generate. It contains the address range check, the zero-register mux and the bypass priority mux, and outputs one DATA_WIDTH word.
- The top level holds the storage array, write logic, FSM and sweep counter.

## Test plan
- **Reset then clear sweep:** hold reset = 0 for 3 cycles, release.
  - ready = 0 for exactly 32 edges, then 1.
  - All rdata = 0 throughout.
  - Every register then reads 0.
- **Basic write/read:** we0, rd0 = 5, wd0 = 0xDEADBEEF; next cycle rs[0] = 5, rs[1] = 5 → both read 0xDEADBEEF.
- **Write collision:** we0 = we1 = 1, rd0 = rd1 = 7, wd0 = 0x11, wd1 = 0x22 → reg[7] = 0x22.
  - Same cycle with BYPASS = 1, rs[0] = 7 → 0x22.
  - With BYPASS = 0 → the old value.
- **Zero register:** we1 = 1, rd1 = 0, wd1 = 0xFFFF → rs = 0 reads 0 in the same and next cycle.
- **Clear in ST_RUN:** write reg[3] = 0xA5, assert clear for 1 cycle together with we0 to reg[4].
  - ready = 0 for 32 edges.
  - reg[4] is not written.
  - reg[3] afterwards reads 0.
- **Reset mid-sweep:** pull reset low at sweep cycle 10 and release → ready rises a full 32 edges after release. Writes attempted during the sweep are ignored.
